// File: rtl/instr_prefix_queue.sv
// Byte-granular circular instruction queue: accepts whole fetch lines, presents a
// 15-byte head window and decodes up to three leading prefixes from it.
module instr_prefix_queue #(
  parameter int QBYTES     = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fill_valid,
  input  logic [8*LINE_BYTES-1:0]   fill_line,
  output logic                      fill_ready,
  input  logic                      flush,
  input  logic                      drain,
  output logic                      out_valid,
  input  logic                      dec_ready,
  input  logic [3:0]                dec_len,
  output logic [7:0]                B1,
  output logic [7:0]                B2,
  output logic [7:0]                B3,
  output logic [7:0]                B4,
  output logic [7:0]                B5,
  output logic [7:0]                B6,
  output logic [119:0]              head_bytes,
  output logic                      isREP,
  output logic                      isSIZE,
  output logic                      isSEG,
  output logic [3:0]                prefSize,
  output logic [5:0]                segSEL,
  output logic                      pref_err,
  output logic [$clog2(QBYTES):0]   count
);

  localparam int PW  = $clog2(QBYTES);
  localparam int CW  = PW + 1;
  localparam int WIN = 15;
  localparam logic [CW-1:0] FILL_MAX = CW'(QBYTES - LINE_BYTES);
  localparam logic [CW-1:0] LINE_CNT = CW'(LINE_BYTES);
  localparam logic [CW-1:0] WIN_CNT  = CW'(WIN);

  function automatic logic is_prefix(input logic [7:0] b);
    case (b)
      8'hF3, 8'h66, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: is_prefix = 1'b1;
      default:                                                is_prefix = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] seg_onehot(input logic [7:0] b);
    case (b)
      8'h26:   seg_onehot = 6'b000001;
      8'h2E:   seg_onehot = 6'b000010;
      8'h36:   seg_onehot = 6'b000100;
      8'h3E:   seg_onehot = 6'b001000;
      8'h64:   seg_onehot = 6'b010000;
      8'h65:   seg_onehot = 6'b100000;
      default: seg_onehot = 6'b000000;
    endcase
  endfunction

  logic [7:0]    mem_q [QBYTES];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] dec_len_s;
  logic [CW-1:0] take_s;
  logic          fill_acc_s;
  logic          cons_s;
  logic [7:0]    win_s [WIN];
  logic [3:0]    pfx_s;
  logic [1:0]    npfx_s;
  logic          counted_s;
  logic [5:0]    seg_s;

  // Handshake and next-state; an over-long drain consume only takes what is held.
  always_comb begin
    fill_ready = (count_q <= FILL_MAX);
    out_valid  = (count_q >= WIN_CNT) || (drain && (count_q != CW'(0)));
    dec_len_s  = CW'(dec_len);
    fill_acc_s = fill_valid && fill_ready;
    cons_s     = out_valid && dec_ready && (dec_len != 4'd0);
    if (cons_s) begin
      take_s = (dec_len_s > count_q) ? count_q : dec_len_s;
    end else begin
      take_s = CW'(0);
    end
    if (flush) begin
      rd_ptr_d = PW'(0);
      wr_ptr_d = PW'(0);
      count_d  = CW'(0);
    end else begin
      rd_ptr_d = rd_ptr_q + take_s[PW-1:0];
      wr_ptr_d = fill_acc_s ? (wr_ptr_q + PW'(LINE_BYTES)) : wr_ptr_q;
      count_d  = count_q + (fill_acc_s ? LINE_CNT : CW'(0)) - take_s;
    end
  end

  // Queue state and byte storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= PW'(0);
      wr_ptr_q <= PW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < QBYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (fill_acc_s && !flush) begin
        for (int i = 0; i < LINE_BYTES; i++) begin
          mem_q[wr_ptr_q + PW'(i)] <= fill_line[8*i +: 8];
        end
      end else begin
        for (int i = 0; i < QBYTES; i++) begin
          mem_q[i] <= mem_q[i];
        end
      end
    end
  end

  // Head window: pointer arithmetic wraps naturally at the buffer end.
  always_comb begin
    head_bytes = 120'd0;
    for (int i = 0; i < WIN; i++) begin
      win_s[i]             = mem_q[rd_ptr_q + PW'(i)];
      head_bytes[8*i +: 8] = win_s[i];
    end
  end

  assign B1    = win_s[0];
  assign B2    = win_s[1];
  assign B3    = win_s[2];
  assign B4    = win_s[3];
  assign B5    = win_s[4];
  assign B6    = win_s[5];
  assign count = count_q;

  // Prefix decode; a fourth prefix byte only flags an error, flags come from bytes 0..2.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pfx_s[i] = is_prefix(win_s[i]);
    end
    if (!pfx_s[0]) begin
      npfx_s = 2'd0;
    end else if (!pfx_s[1]) begin
      npfx_s = 2'd1;
    end else if (!pfx_s[2]) begin
      npfx_s = 2'd2;
    end else begin
      npfx_s = 2'd3;
    end
    isREP     = 1'b0;
    isSIZE    = 1'b0;
    isSEG     = 1'b0;
    segSEL    = 6'b000000;
    counted_s = 1'b0;
    seg_s     = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      counted_s = (i < int'(npfx_s));
      seg_s     = counted_s ? seg_onehot(win_s[i]) : 6'b000000;
      isREP     = isREP  | (counted_s && (win_s[i] == 8'hF3));
      isSIZE    = isSIZE | (counted_s && (win_s[i] == 8'h66));
      isSEG     = isSEG  | (seg_s != 6'b000000);
      segSEL    = (seg_s != 6'b000000) ? seg_s : segSEL;
    end
    prefSize = 4'b0001 << npfx_s;
    pref_err = &pfx_s;
  end

endmodule

// File: tb/tb_instr_prefix_queue.sv
// Randomized bench for instr_prefix_queue against an address-based byte-store model.
module tb_instr_prefix_queue;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fill_valid = 1'b0;
  logic [127:0] fill_line = 128'd0;
  logic         fill_ready;
  logic         flush = 1'b0;
  logic         drain = 1'b0;
  logic         out_valid;
  logic         dec_ready = 1'b0;
  logic [3:0]   dec_len = 4'd0;
  logic [7:0]   B1, B2, B3, B4, B5, B6;
  logic [119:0] head_bytes;
  logic         isREP, isSIZE, isSEG;
  logic [3:0]   prefSize;
  logic [5:0]   segSEL;
  logic         pref_err;
  logic [5:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_mem [32];
  int         m_rd, m_wr, m_cnt;

  instr_prefix_queue #(.QBYTES(32), .LINE_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n), .fill_valid(fill_valid), .fill_line(fill_line),
    .fill_ready(fill_ready), .flush(flush), .drain(drain), .out_valid(out_valid),
    .dec_ready(dec_ready), .dec_len(dec_len), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .B5(B5), .B6(B6), .head_bytes(head_bytes), .isREP(isREP), .isSIZE(isSIZE),
    .isSEG(isSEG), .prefSize(prefSize), .segSEL(segSEL), .pref_err(pref_err),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_pfx(input logic [7:0] b);
    return b inside {8'hF3, 8'h66, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
  endfunction

  function automatic logic [5:0] seg_of(input logic [7:0] b);
    case (b)
      8'h26:   return 6'b000001;
      8'h2E:   return 6'b000010;
      8'h36:   return 6'b000100;
      8'h3E:   return 6'b001000;
      8'h64:   return 6'b010000;
      8'h65:   return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [7:0] rnd_byte();
    logic [7:0] pl [8] = '{8'hF3, 8'h66, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    if ($urandom_range(3, 0) < 2) return pl[$urandom_range(7, 0)];
    return 8'($urandom);
  endfunction

  function automatic logic [127:0] rnd_line();
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = rnd_byte();
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_rd = 0; m_wr = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    logic [7:0]   w [15];
    logic [119:0] hb;
    logic [5:0]   seg;
    logic         rep, siz, sg;
    int           k, n;
    for (int i = 0; i < 15; i++) begin
      w[i] = m_mem[(m_rd + i) % 32];
      hb[8*i +: 8] = w[i];
    end
    k = 0;
    while (k < 4 && is_pfx(w[k])) k++;
    n = (k > 3) ? 3 : k;
    rep = 1'b0; siz = 1'b0; sg = 1'b0; seg = 6'b0;
    for (int j = 0; j < n; j++) begin
      if (w[j] == 8'hF3) rep = 1'b1;
      if (w[j] == 8'h66) siz = 1'b1;
      if (seg_of(w[j]) != 6'b0) begin
        sg = 1'b1;
        seg = seg_of(w[j]);
      end
    end
    chk_eq({tag, ".count"},     count,      128'(m_cnt));
    chk_eq({tag, ".fill_ready"}, fill_ready, 128'((32 - m_cnt) >= 16));
    chk_eq({tag, ".out_valid"}, out_valid,  128'((m_cnt >= 15) || (drain && m_cnt >= 1)));
    chk_eq({tag, ".head"},      head_bytes, 128'(hb));
    chk_eq({tag, ".B1"}, B1, 128'(w[0]));
    chk_eq({tag, ".B2"}, B2, 128'(w[1]));
    chk_eq({tag, ".B3"}, B3, 128'(w[2]));
    chk_eq({tag, ".B4"}, B4, 128'(w[3]));
    chk_eq({tag, ".B5"}, B5, 128'(w[4]));
    chk_eq({tag, ".B6"}, B6, 128'(w[5]));
    chk_eq({tag, ".isREP"},  isREP,  128'(rep));
    chk_eq({tag, ".isSIZE"}, isSIZE, 128'(siz));
    chk_eq({tag, ".isSEG"},  isSEG,  128'(sg));
    chk_eq({tag, ".segSEL"}, segSEL, 128'(seg));
    chk_eq({tag, ".prefSize"}, prefSize, 128'(1 << n));
    chk_eq({tag, ".pref_err"}, pref_err, 128'(k == 4));
  endtask

  task automatic model_step();
    bit fr, ov, cons;
    int take;
    fr = (32 - m_cnt) >= 16;
    ov = (m_cnt >= 15) || (drain && m_cnt >= 1);
    if (flush) begin
      m_rd = 0; m_wr = 0; m_cnt = 0;
    end else begin
      cons = ov && dec_ready && (dec_len != 4'd0);
      take = cons ? ((int'(dec_len) > m_cnt) ? m_cnt : int'(dec_len)) : 0;
      if (fill_valid && fr) begin
        for (int i = 0; i < 16; i++) m_mem[(m_wr + i) % 32] = fill_line[8*i +: 8];
        m_wr = (m_wr + 16) % 32;
        m_cnt += 16;
      end
      m_rd = (m_rd + take) % 32;
      m_cnt -= take;
    end
  endtask

  task automatic tick(input string tag, input logic fv, input logic [127:0] line,
                      input logic fl, input logic dr, input logic rdy, input logic [3:0] len);
    fill_valid = fv; fill_line = line; flush = fl; drain = dr; dec_ready = rdy; dec_len = len;
    @(negedge clk);
    check_all(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    chk_eq("reset.prefSize", prefSize, 128'(4'b0001));
    chk_eq("reset.fill_ready", fill_ready, 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // line fills: byte value = index
    tick("fill1", 1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_eq("t2.out_valid", out_valid, 128'(1'b1));
    chk_eq("t2.B1", B1, 128'(8'h00));
    chk_eq("t2.B6", B6, 128'(8'h05));
    tick("fill2", 1'b1, 128'h1F1E1D1C1B1A19181716151413121110, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_eq("t2.count32", count, 128'(6'd32));
    chk_eq("t2.fill_ready0", fill_ready, 128'(1'b0));

    // prefix patterns
    tick("fl3", 1'b0, 128'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick("p3", 1'b1, 128'h0000_0000_0000_0000_0000_C3AF_0F2E_66F3, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_eq("t3.prefSize", prefSize, 128'(4'b1000));
    chk_eq("t3.flags", {isREP, isSIZE, isSEG}, 128'(3'b111));
    chk_eq("t3.segSEL", segSEL, 128'(6'b000010));
    chk_eq("t3.pref_err", pref_err, 128'(1'b0));
    tick("fl3b", 1'b0, 128'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick("p2", 1'b1, 128'h0000_0000_0000_0000_0000_0000_C301_6526, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_eq("t3b.prefSize", prefSize, 128'(4'b0100));
    chk_eq("t3b.segSEL", segSEL, 128'(6'b100000));
    tick("fl4", 1'b0, 128'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick("p4", 1'b1, 128'h0000_0000_0000_0000_0000_0090_6666_6666, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_eq("t4.pref_err", pref_err, 128'(1'b1));
    chk_eq("t4.prefSize", prefSize, 128'(4'b1000));

    // wrap-around and full-queue fill refusal
    tick("w0", 1'b0, 128'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick("w1", 1'b1, rnd_line(), 1'b0, 1'b0, 1'b0, 4'd0);
    tick("w2", 1'b1, rnd_line(), 1'b0, 1'b0, 1'b0, 4'd0);
    tick("w3", 1'b0, 128'd0, 1'b0, 1'b0, 1'b1, 4'd15);
    tick("w4", 1'b0, 128'd0, 1'b0, 1'b0, 1'b1, 4'd1);
    tick("w5", 1'b1, rnd_line(), 1'b0, 1'b0, 1'b1, 4'd12);
    chk_eq("t5.count20", count, 128'(6'd20));
    chk_eq("t5.fill_ready0", fill_ready, 128'(1'b0));
    tick("w6", 1'b1, rnd_line(), 1'b0, 1'b0, 1'b1, 4'd3);
    chk_eq("t5.count17", count, 128'(6'd17));
    tick("w7", 1'b0, 128'd0, 1'b0, 1'b0, 1'b1, 4'd1);
    tick("w8", 1'b1, rnd_line(), 1'b0, 1'b0, 1'b1, 4'd3);
    chk_eq("t5.count29", count, 128'(6'd29));

    // flush priority, ignored consume, drain saturation
    tick("f1", 1'b1, rnd_line(), 1'b1, 1'b0, 1'b1, 4'd4);
    chk_eq("t6.count0", count, 128'(6'd0));
    chk_eq("t6.out_valid0", out_valid, 128'(1'b0));
    tick("d1", 1'b1, rnd_line(), 1'b0, 1'b0, 1'b0, 4'd0);
    tick("d2", 1'b0, 128'd0, 1'b0, 1'b0, 1'b1, 4'd13);
    tick("d3", 1'b0, 128'd0, 1'b0, 1'b0, 1'b1, 4'd2);
    chk_eq("t6.ignored", count, 128'(6'd3));
    tick("d4", 1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk_eq("t6.drain_valid", out_valid, 128'(1'b1));
    tick("d5", 1'b0, 128'd0, 1'b0, 1'b1, 1'b1, 4'd5);
    chk_eq("t6.drain_sat", count, 128'(6'd0));

    for (int c = 0; c < 600; c++) begin
      tick("rnd", 1'($urandom_range(2, 0) != 0), rnd_line(), 1'($urandom_range(49, 0) == 0),
           1'($urandom_range(7, 0) == 0), 1'($urandom_range(3, 0) != 0),
           4'($urandom_range(15, 0)));
    end

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    chk_eq("midrst.count", count, 128'(6'd0));
    fill_valid = 1'b0; flush = 1'b0; drain = 1'b0; dec_ready = 1'b0; dec_len = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("midrst.fill_ready", fill_ready, 128'(1'b1));
    tick("post", 1'b1, rnd_line(), 1'b0, 1'b0, 1'b0, 4'd0);
    check_all("post2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_prefix_queue.md
# instr_prefix_queue

Byte-granular instruction queue that sits directly upstream of the control-store top. It absorbs 16-byte fetch lines into a 32-byte circular buffer and presents the head instruction window as B1..B6. It decodes up to three leading prefixes into isREP / isSIZE / isSEG / prefSize / segSEL, and retires a variable number of bytes per cycle under a valid/ready handshake with the decode stage.

## Interface

Parameters
- QBYTES, 32, queue capacity in bytes; power of two, ≥ 2×LINE_BYTES.
- LINE_BYTES, 16, bytes per fetch line.

Ports
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: the single clock.
  - rst_n, in, 1: asynchronous active-low reset.
- Fetch side:
  - fill_valid, in, 1: fetch line present.
  - fill_line, in, 8·LINE_BYTES: fetch line; byte 0 = fill_line[7:0] = lowest address.
  - fill_ready, out, 1: queue can accept a full line.
- Queue control:
  - flush, in, 1: synchronous empty; used on branch redirect.
  - drain, in, 1: allows out_valid with fewer than 15 bytes (end of stream).
- Decode-side handshake:
  - out_valid, out, 1: head window valid.
  - dec_ready, in, 1: decode accepts the head instruction.
  - dec_len, in, 4: total instruction length including prefixes; legal range 1..15.
- Head window:
  - B1..B6, out, 8 each: head bytes 0..5 (B1 = oldest byte).
  - head_bytes, out, 120: head bytes 0..14 (byte 0 in [7:0]).
- Prefix decode:
  - isREP, out, 1: an F3 prefix is present.
  - isSIZE, out, 1: a 66 prefix is present.
  - isSEG, out, 1: a segment override is present.
  - prefSize, out, 4: one-hot count of prefixes; bit n set means n prefixes (0..3).
  - segSEL, out, 6: one-hot segment select; bits 0..5 = ES, CS, SS, DS, FS, GS.
  - pref_err, out, 1: four or more leading prefixes.
- Status:
  - count, out, 6: bytes currently held.

## Operation

State
- Byte array mem[QBYTES], 5-bit rd_ptr and wr_ptr (modulo QBYTES), and a 6-bit count.

Fill
- Fill is accepted when fill_valid && fill_ready.
- fill_ready = (QBYTES − count) ≥ LINE_BYTES.
- fill_ready is computed from the current count only; there is no same-cycle bypass from a consume.
- On accept, bytes are written at wr_ptr..wr_ptr+15 with wrap, and wr_ptr += 16.

Consume
- Consume occurs when out_valid && dec_ready && dec_len ≠ 0.
- On consume, rd_ptr += dec_len with wrap.
- dec_len = 0 is a no-op.
- dec_len > count (possible only under drain) saturates: rd_ptr = wr_ptr and count = 0.

Count update
- count_next = count + 16·fill − dec_len·consume.
- Simultaneous fill and consume are both applied in the same cycle.

Output valid
- out_valid = (count ≥ 15) || (drain && count ≥ 1).

Head window
- Window byte i = mem[(rd_ptr + i) mod QBYTES].
- Outputs are combinational from registered state only; they do not depend on fill or dec inputs in the same cycle.

Prefix decode
- Scan head bytes 0, 1, 2 in order; stop at the first non-prefix byte.
- Prefix set: F3, 66, 26, 2E, 36, 3E, 64, 65.
- Number of prefixes n ∈ 0..3; prefSize = 1 << n.
- isREP / isSIZE / isSEG are set if any counted prefix matches the respective class.
- segSEL: the last counted segment prefix wins (26 = ES, 2E = CS, 36 = SS, 3E = DS, 64 = FS, 65 = GS); 0 if there is none.
- Duplicate prefixes each count toward n.
- If bytes 0..3 are all prefixes: pref_err = 1, prefSize = 4'b1000, and flags are decoded from bytes 0..2.

Flush
- flush has priority over fill and consume in the same cycle.
- Result: rd_ptr = wr_ptr = 0, count = 0. mem is not cleared.

## Timing

Reset values (rst_n low, asynchronous)
- Pointers and count 0; mem all 0x00.
- Hence out_valid 0, B1..B6 = 00, head_bytes 0.
- prefSize = 4'b0001, isREP = isSIZE = isSEG = 0, segSEL = 0, pref_err 0, fill_ready 1, count 0.

Latency
- A line accepted in cycle N is visible in the window in cycle N+1.
- From empty, the first accepted line (16 bytes) raises out_valid in N+1.
- A consume in cycle N advances the window in N+1; prefix outputs update in the same cycle N+1.

Throughput and stall rules
- Throughput: one instruction per cycle while count stays ≥ 15 (drain = 0).
- Full: count > 16 deasserts fill_ready; fetch must hold fill_line stable until accepted.
- out_valid may fall while dec_ready is high. Decode must not consume without out_valid; the block ignores such attempts.

Boundaries
- Wrap-around: rd_ptr and wr_ptr wrap mod 32; the window read across 31→0 must be seamless.
- Reset asserted mid-operation: all state clears immediately; fill_ready is 1 on the first edge after release.

## Test plan

1. Reset → count 0, fill_ready 1, out_valid 0, prefSize 0001, segSEL 000000.
2. Fill line 00..0F (byte value = index) then fill 10..1F.
   - After the first fill: out_valid 1, B1 = 00, B6 = 05.
   - After the second fill: count 32, fill_ready 0.
3. Head bytes F3 66 2E 0F AF C3 → prefSize 1000? No: n = 3, prefSize 1000, isREP = isSIZE = isSEG = 1, segSEL 000010, pref_err 0. Head bytes 26 65 01 C3 → prefSize 0100, segSEL 100000.
4. Head bytes 66 66 66 66 90 → pref_err 1, prefSize 1000.
5. count 20, rd_ptr 28: fill + consume dec_len 3 in the same cycle.
   - Next cycle: count 33 is illegal, so the fill must not be accepted (fill_ready was 0).
   - Repeat from count 16: next count 29; window crosses 31→0 correctly.
6. Flush with fill_valid and consume both asserted → next cycle count 0, out_valid 0. Drain with 3 bytes left: out_valid 1; dec_len 5 → count 0.
